// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard beside ID: tracks in-flight writes across DEPTH post-ID
// stages, raises stall for unresolved hazards and registers the EX forwarding selects.
module hazard_scoreboard #(
  parameter int unsigned REGBITS     = 5,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned NSRC        = 2,
  parameter int unsigned LATW        = 2,
  parameter int unsigned FWD_EN      = 1,
  parameter int unsigned FLUSH_SLOTS = 2,
  parameter int unsigned SELW        = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic [REGBITS-1:0]       issue_wa,
  input  logic [LATW-1:0]          issue_lat,
  input  logic [NSRC*REGBITS-1:0]  id_src,
  input  logic                     flush,
  output logic                     stall,
  output logic [NSRC*SELW-1:0]     ex_fwd_sel,
  output logic [15:0]              perf_stall
);

  // Slot DEPTH-1 (WB) is never searched: the write-through register file covers it.
  localparam int unsigned SRCH = DEPTH - 1;

  logic [DEPTH-1:0]   slot_valid;
  logic [REGBITS-1:0] slot_wa  [DEPTH];
  logic [LATW-1:0]    slot_lat [DEPTH];

  logic [NSRC-1:0]    op_found;
  logic [NSRC-1:0]    op_ready;
  logic [SELW-1:0]    op_sel [NSRC];
  logic               hazard;
  logic [NSRC*SELW-1:0] fwd_next;
  logic               issue_ok;
  logic [LATW-1:0]    issue_lat_eff;

  // Youngest-match search per operand; descending loop lets the lowest slot win.
  always_comb begin
    op_found = '0;
    op_ready = '0;
    hazard   = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      op_sel[i] = '0;
      for (int s = int'(SRCH) - 1; s >= 0; s--) begin
        if ((id_src[i*REGBITS +: REGBITS] != '0) && slot_valid[s] &&
            (slot_wa[s] == id_src[i*REGBITS +: REGBITS])) begin
          op_found[i] = 1'b1;
          op_sel[i]   = SELW'(s + 1);
          op_ready[i] = ((s + 1) >= int'(slot_lat[s]));
        end
      end
      hazard = hazard | (op_found[i] & (~op_ready[i] | (FWD_EN == 0)));
    end
  end

  always_comb begin
    stall    = issue_valid & ~flush & hazard;
    fwd_next = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (issue_valid && !stall && !flush && op_found[i] && op_ready[i] && (FWD_EN != 0)) begin
        fwd_next[i*SELW +: SELW] = op_sel[i];
      end
    end
    issue_ok      = issue_valid & issue_we & (issue_wa != '0) & ~stall & ~flush;
    issue_lat_eff = (issue_lat == '0) ? LATW'(1) : issue_lat;
  end

  // Shift register of in-flight writes; flush squashes the youngest FLUSH_SLOTS entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      for (int s = 0; s < int'(DEPTH); s++) begin
        slot_wa[s]  <= '0;
        slot_lat[s] <= '0;
      end
    end else begin
      slot_valid[0] <= issue_ok;
      slot_wa[0]    <= issue_wa;
      slot_lat[0]   <= issue_lat_eff;
      for (int s = 1; s < int'(DEPTH); s++) begin
        slot_valid[s] <= slot_valid[s-1] & ~(flush & (s < int'(FLUSH_SLOTS)));
        slot_wa[s]    <= slot_wa[s-1];
        slot_lat[s]   <= slot_lat[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_fwd_sel <= '0;
      perf_stall <= '0;
    end else begin
      ex_fwd_sel <= fwd_next;
      if (stall && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the fixed two-operand forwarding/hazard-detection logic of the five-stage MIPS pipeline. It tracks every in-flight register write in a shift-register scoreboard of DEPTH post-ID stages, and supports per-instruction result latency, any number of source operands, flush, and an optional no-forwarding mode. It sits beside the ID stage. From the ID-stage source registers it produces the stall signal, and it registers the EX-stage forwarding selects the datapath muxes consume one cycle later.

## Interface
- REGBITS, 5, register-address width
- DEPTH, 3, tracked stages after ID (slot 0 = EX, slot DEPTH-1 = WB)
- NSRC, 2, source operands checked per instruction
- LATW, 2, width of issue_lat
- FWD_EN, 1, 1 = forward from slots; 0 = stall on any pending match
- FLUSH_SLOTS, 2, slots cleared by flush (1..DEPTH)
- SELW, $clog2(DEPTH), select width (derived)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- issue_valid  in  1  valid instruction in ID
- issue_we  in  1  ID instruction writes a register
- issue_wa  in  REGBITS  ID destination register
- issue_lat  in  LATW  slot index at which the result becomes forwardable (ALU = 1, load = 2)
- id_src  in  NSRC*REGBITS  ID source registers, operand i at [i*REGBITS +: REGBITS]
- flush  in  1  squash younger instructions (branch/jump taken)
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- ex_fwd_sel  out  NSRC*SELW  per-operand EX select: 0 = register file, k = stage slot k (1 = MEM, 2 = WB)
- perf_stall  out  16  saturating count of stall cycles

## Operation
- State per slot s: valid, wa, lat. Every clock, slot s shifts into slot s+1, and slot DEPTH-1 is dropped. The register file is write-through, so dropped results are visible to ID.
- Slot 0 load: {issue_valid & issue_we & issue_wa!=0 & !stall & !flush, issue_wa, max(issue_lat,1)}. Otherwise slot 0 becomes invalid (bubble).
- Per operand i, when id_src[i]==0 the operand is never hazarded and its select is 0.
- Match search covers slots 0..DEPTH-2 with valid & wa==id_src[i]. The youngest (lowest s) match wins; older matches are ignored.
- A match is ready when s+1 >= lat, i.e. the producer reaches a forwardable stage when the consumer is in EX.
- Hazard when a match exists and either it is not ready or FWD_EN==0.
- stall = issue_valid & !flush & OR over operands of the hazard.
- Next ex_fwd_sel[i] = (!stall & !flush & match ready & FWD_EN) ? s+1 : 0. It is loaded every cycle, and a bubble carries 0.
- Flush: issue is suppressed. After the edge, slots 0..FLUSH_SLOTS-1 are invalid, and ex_fwd_sel becomes 0.
- perf_stall increments on each edge with stall==1 and holds at 16'hFFFF.

## Timing
- Reset (reset==0, asynchronous): all slots invalid, ex_fwd_sel=0, perf_stall=0. stall is combinational, so it reads 0 whenever issue_valid==0 or no slot is valid.
- stall is combinational from the ID inputs and slot state within the same cycle.
- ex_fwd_sel has 1-cycle latency: it is valid in the cycle the consumer occupies EX.
- Back-to-back ALU producer→consumer: 0 stall cycles, select 1.
- Load→use: exactly 1 stall cycle, then select 2.
- Producer in WB when the consumer is in ID: no stall, select 0 (write-through).
- flush and stall in the same cycle: flush wins, stall=0, and the counter does not increment.
- Reset deasserted mid-stall: the next cycle starts from the empty scoreboard, with stall=0.

## Test plan
- ALU→ALU dependence: issue wa=5 lat=1, then src0=5 -> stall stays 0; next cycle ex_fwd_sel op0=1.
- Load→use: wa=8 lat=2, then src1=8 -> stall=1 for exactly one cycle, perf_stall=1; ex_fwd_sel op1=2 when the consumer reaches EX.
- Dependence on $0 and on distance-3 producer: issue wa=0, then src0=0 -> no stall, select 0. Producer three instructions older -> select 0.
- Youngest-match priority: wa=4 lat=1, then wa=4 lat=2, then src0=4 -> 1 stall (youngest is the load), then select 2. The older entry is never selected.
- Flush: load wa=9 lat=2, src0=9 stalling, and flush=1 in the same cycle -> stall=0; next cycle slots 0..1 invalid, ex_fwd_sel=0; src0=9 afterwards -> no stall.
- FWD_EN=0 build: ALU wa=3, then src0=3 -> stall=1 for 2 cycles, until the producer leaves slot DEPTH-2; select 0. Separately, hold a hazard for 70000 cycles -> perf_stall saturates at 16'hFFFF. Assert reset mid-stall -> all outputs 0 immediately.
